// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between two masters, the arbiter and the shared data RAM
interface mem_arbiter_if;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_we_i;
  logic [1:0]  m1_hb_i;
  logic        m1_uload_i;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic [31:0] m1_rdata_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [1:0]  ram_hb_o;
  logic        ram_uload_o;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i, m1_uload_i,
    input  ram_rdata_i,
    output m0_ack_o, m0_err_o, m0_rdata_o,
    output m1_ack_o, m1_err_o, m1_rdata_o,
    output ram_addr_o, ram_wdata_o, ram_we_o, ram_hb_o, ram_uload_o
  );

  modport master (
    output m0_req_i, m0_addr_i,
    output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i, m1_uload_i,
    output ram_rdata_i,
    input  m0_ack_o, m0_err_o, m0_rdata_o,
    input  m1_ack_o, m1_err_o, m1_rdata_o,
    input  ram_addr_o, ram_wdata_o, ram_we_o, ram_hb_o, ram_uload_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter/sequencer for the shared single-port data RAM
module mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic        sel_q, we_q, uload_q, err_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  hb_q;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;

  logic        grant_m1;
  logic [31:0] cand_addr;
  logic [1:0]  cand_hb;
  logic        cand_err;
  logic [31:0] rd_capture;

  always_comb begin
    // on a round-robin tie the master not granted last time wins
    grant_m1  = bus.m1_req_i & (~bus.m0_req_i | FIXED_PRIO | ~last_grant);
    cand_addr = grant_m1 ? bus.m1_addr_i : bus.m0_addr_i;
    cand_hb   = grant_m1 ? bus.m1_hb_i : 2'b10;
    cand_err  = (cand_addr >= ADDR_LIMIT)
              | (cand_hb == 2'b11)
              | ((cand_hb == 2'b01) & cand_addr[0])
              | ((cand_hb == 2'b10) & (cand_addr[1:0] != 2'b00));
    rd_capture = (~we_q & ~err_q) ? bus.ram_rdata_i : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      uload_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      hb_q       <= 2'b00;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'd0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'd0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m0_req_i | bus.m1_req_i) begin
            state      <= ACCESS;
            sel_q      <= grant_m1;
            last_grant <= grant_m1;
            addr_q     <= cand_addr;
            wdata_q    <= grant_m1 ? bus.m1_wdata_i : 32'd0;
            we_q       <= grant_m1 & bus.m1_we_i;
            hb_q       <= cand_hb;
            uload_q    <= grant_m1 & bus.m1_uload_i;
            err_q      <= cand_err;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (sel_q) begin
            m1_ack   <= 1'b1;
            m1_err   <= err_q;
            m1_rdata <= rd_capture;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= err_q;
            m0_rdata <= rd_capture;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // write strobe is not gated by reset: the RAM itself has no reset
  assign bus.ram_we_o    = (state == ACCESS) & we_q & ~err_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.ram_hb_o    = hb_q;
  assign bus.ram_uload_o = uload_q;
  assign bus.m0_ack_o    = m0_ack;
  assign bus.m0_err_o    = m0_err;
  assign bus.m0_rdata_o  = m0_rdata;
  assign bus.m1_ack_o    = m1_ack;
  assign bus.m1_err_o    = m1_err;
  assign bus.m1_rdata_o  = m1_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter (round-robin and fixed-priority builds)
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic preload;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();
  mem_arbiter_if bus_fp ();

  mem_arbiter #(.ADDR_LIMIT(32'd1024), .FIXED_PRIO(1'b0)) dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus));
  mem_arbiter #(.ADDR_LIMIT(32'd1024), .FIXED_PRIO(1'b1)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_a [0:255];

  function automatic logic [31:0] ram_rd(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] hb, input logic ul);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a[1:0], 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (hb)
      2'b00:   return ul ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return ul ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign bus.ram_rdata_i    = ram_rd(mem_a[bus.ram_addr_o[9:2]], bus.ram_addr_o, bus.ram_hb_o, bus.ram_uload_o);
  assign bus_fp.ram_rdata_i = ram_rd(mem_a[bus_fp.ram_addr_o[9:2]], bus_fp.ram_addr_o, bus_fp.ram_hb_o, bus_fp.ram_uload_o);

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'd0;
      mem_a[0] <= 32'hCAFEF00D;
      mem_a[4] <= 32'h12345678;
    end else if (bus.ram_we_o) begin
      case (bus.ram_hb_o)
        2'b00: mem_a[bus.ram_addr_o[9:2]][{bus.ram_addr_o[1:0], 3'b000} +: 8] <= bus.ram_wdata_o[7:0];
        2'b01: begin
          if (bus.ram_addr_o[1]) mem_a[bus.ram_addr_o[9:2]][31:16] <= bus.ram_wdata_o[15:0];
          else                   mem_a[bus.ram_addr_o[9:2]][15:0]  <= bus.ram_wdata_o[15:0];
        end
        default: mem_a[bus.ram_addr_o[9:2]] <= bus.ram_wdata_o;
      endcase
    end
  end

  typedef struct {
    string       name;
    bit          m1;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    logic [1:0]  hb;
    bit          ul;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input string n, input bit m1, input logic [31:0] a, input logic [31:0] wd,
                              input bit we, input logic [1:0] hb, input bit ul, input bit e, input logic [31:0] rd);
    vec_t v;
    v.name = n; v.m1 = m1; v.addr = a; v.wdata = wd; v.we = we; v.hb = hb; v.ul = ul;
    v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, we_cnt;
    bit other;
    lat = 0; we_cnt = 0; other = 0;
    @(negedge clk);
    if (v.m1) begin
      bus.m1_req_i = 1'b1; bus.m1_addr_i = v.addr; bus.m1_wdata_i = v.wdata;
      bus.m1_we_i = v.we; bus.m1_hb_i = v.hb; bus.m1_uload_i = v.ul;
    end else begin
      bus.m0_req_i = 1'b1; bus.m0_addr_i = v.addr;
    end
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.ram_we_o) we_cnt++;
      if ((v.m1 ? bus.m0_ack_o : bus.m1_ack_o) === 1'b1) other = 1;
      if ((v.m1 ? bus.m1_ack_o : bus.m0_ack_o) === 1'b1) begin
        lat = c;
        chk({v.name, " err"}, 32'(v.m1 ? bus.m1_err_o : bus.m0_err_o), 32'(v.exp_err));
        chk({v.name, " rdata"}, v.m1 ? bus.m1_rdata_o : bus.m0_rdata_o, v.exp_rdata);
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
      end
    end
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    chk({v.name, " latency"}, 32'(lat), 32'd2);
    chk({v.name, " we_cycles"}, 32'(we_cnt), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    chk({v.name, " other_ack"}, 32'(other), 32'd0);
    @(negedge clk);
    chk({v.name, " ack_clear"}, 32'({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   ord [4];
    int   tim [4];
    int   both;
    int   n1, t0;
    int   t1 [3];
    logic got;
    vec_t v;

    checks = 0; errors = 0;
    rst = 1'b1; preload = 1'b1;
    bus.m0_req_i = 0; bus.m0_addr_i = 0; bus.m1_req_i = 0; bus.m1_addr_i = 0;
    bus.m1_wdata_i = 0; bus.m1_we_i = 0; bus.m1_hb_i = 0; bus.m1_uload_i = 0;
    bus_fp.m0_req_i = 0; bus_fp.m0_addr_i = 0; bus_fp.m1_req_i = 0; bus_fp.m1_addr_i = 0;
    bus_fp.m1_wdata_i = 0; bus_fp.m1_we_i = 0; bus_fp.m1_hb_i = 0; bus_fp.m1_uload_i = 0;

    vecs[0]  = mk("fetch_0x10",     0, 32'h010, 0,            0, 2'b10, 0, 0, 32'h12345678);
    vecs[1]  = mk("st_byte_0x21",   1, 32'h021, 32'h000000A5, 1, 2'b00, 0, 0, 32'h0);
    vecs[2]  = mk("ld_sbyte_0x21",  1, 32'h021, 0,            0, 2'b00, 0, 0, 32'hFFFFFFA5);
    vecs[3]  = mk("ld_ubyte_0x21",  1, 32'h021, 0,            0, 2'b00, 1, 0, 32'h000000A5);
    vecs[4]  = mk("st_half_0x03",   1, 32'h003, 32'h00001234, 1, 2'b01, 0, 1, 32'h0);
    vecs[5]  = mk("ld_word_0x00",   1, 32'h000, 0,            0, 2'b10, 0, 0, 32'hCAFEF00D);
    vecs[6]  = mk("fetch_0x400",    0, 32'h400, 0,            0, 2'b10, 0, 1, 32'h0);
    vecs[7]  = mk("ld_hb11",        1, 32'h000, 0,            0, 2'b11, 0, 1, 32'h0);
    vecs[8]  = mk("ld_word_0x02",   1, 32'h002, 0,            0, 2'b10, 0, 1, 32'h0);
    vecs[9]  = mk("st_half_0x22",   1, 32'h022, 32'h0000BEEF, 1, 2'b01, 0, 0, 32'h0);
    vecs[10] = mk("ld_uhalf_0x22",  1, 32'h022, 0,            0, 2'b01, 1, 0, 32'h0000BEEF);
    vecs[11] = mk("ld_shalf_0x22",  1, 32'h022, 0,            0, 2'b01, 0, 0, 32'hFFFFBEEF);
    vecs[12] = mk("ld_word_0x20",   1, 32'h020, 0,            0, 2'b10, 0, 0, 32'hBEEFA500);
    vecs[13] = mk("st_word_0x3fc",  1, 32'h3FC, 32'h89ABCDEF, 1, 2'b10, 0, 0, 32'h0);
    vecs[14] = mk("fetch_0x3fc",    0, 32'h3FC, 0,            0, 2'b10, 0, 0, 32'h89ABCDEF);
    vecs[15] = mk("ld_ubyte_0x3ff", 1, 32'h3FF, 0,            0, 2'b00, 1, 0, 32'h00000089);
    vecs[16] = mk("st_byte_0x400",  1, 32'h400, 32'h00000011, 1, 2'b00, 0, 1, 32'h0);
    vecs[17] = mk("fetch_0x3fe",    0, 32'h3FE, 0,            0, 2'b10, 0, 1, 32'h0);

    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    chk("reset outputs", {bus.m0_rdata_o ^ bus.m1_rdata_o, 31'd0, bus.m0_ack_o | bus.m1_ack_o}, 64'd0);
    chk("reset ram bus", bus.ram_addr_o | bus.ram_wdata_o | {27'd0, bus.ram_hb_o, bus.ram_uload_o, bus.ram_we_o, bus.m0_err_o | bus.m1_err_o}, 32'd0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // round-robin from reset with both masters requesting continuously
    do_reset();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h010;
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h020; bus.m1_we_i = 1'b0; bus.m1_hb_i = 2'b10; bus.m1_uload_i = 1'b0;
    n = 0; both = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.m0_ack_o && bus.m1_ack_o) both++;
      if (n < 4 && (bus.m0_ack_o || bus.m1_ack_o)) begin
        ord[n] = bus.m1_ack_o ? 1 : 0;
        tim[n] = c;
        n++;
      end
    end
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
    chk("rr ack count", 32'(n), 32'd4);
    chk("rr simultaneous", 32'(both), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        chk($sformatf("rr grant%0d master", k), 32'(ord[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("rr grant%0d cycle", k), 32'(tim[k]), 32'(2 + 3 * k));
      end
    end
    chk("rr m0 rdata", bus.m0_rdata_o, 32'h12345678);
    chk("rr m1 rdata", bus.m1_rdata_o, 32'hBEEFA500);
    repeat (3) @(negedge clk);

    // reset asserted in the DONE cycle of an m1 load
    do_reset();
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h010; bus.m1_hb_i = 2'b10; bus.m1_we_i = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (bus.m1_ack_o) begin
        got = 1'b1;
        chk("mid_rst load rdata", bus.m1_rdata_o, 32'h12345678);
        rst = 1'b1;
        bus.m1_req_i = 1'b0;
      end
    end
    bus.m1_req_i = 1'b0;
    chk("mid_rst ack seen", 32'(got), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst ack cleared", 32'({bus.m1_ack_o, bus.m1_err_o}), 32'd0);
    chk("mid_rst rdata reset", bus.m1_rdata_o, 32'd0);
    chk("mid_rst ram bus reset", bus.ram_addr_o | {29'd0, bus.ram_hb_o, bus.ram_we_o}, 32'd0);
    v = mk("post_rst_fetch", 0, 32'h010, 0, 0, 2'b10, 0, 0, 32'h12345678);
    run_vec(v);

    // fixed priority: m1 keeps winning until it drops its request
    do_reset();
    bus_fp.m0_req_i = 1'b1; bus_fp.m0_addr_i = 32'h010;
    bus_fp.m1_req_i = 1'b1; bus_fp.m1_addr_i = 32'h000; bus_fp.m1_hb_i = 2'b10; bus_fp.m1_we_i = 1'b0;
    n1 = 0; t0 = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus_fp.m1_ack_o) begin
        if (n1 < 3) t1[n1] = c;
        n1++;
        if (n1 == 3) bus_fp.m1_req_i = 1'b0;
      end
      if (bus_fp.m0_ack_o && t0 == 0) begin
        t0 = c;
        chk("fp m0 rdata", bus_fp.m0_rdata_o, 32'h12345678);
        bus_fp.m0_req_i = 1'b0;
      end
    end
    bus_fp.m0_req_i = 1'b0; bus_fp.m1_req_i = 1'b0;
    chk("fp m1 ack count", 32'(n1), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < n1) chk($sformatf("fp m1 ack%0d cycle", k), 32'(t1[k]), 32'(2 + 3 * k));
    end
    chk("fp m0 ack cycle", 32'(t0), 32'd11);
    chk("fp m1 rdata", bus_fp.m1_rdata_o, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
